// File: rtl/pq_buffer_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pq_buffer_ctrl_pkg
// Shared definitions for the ping-pong buffer sequencer: the state encoding
// and the buffer depth derivation from the address width.
// No ports (package).
// ---------------------------------------------------------------------------
package pq_buffer_ctrl_pkg;

    // State encoding kept as plain constants so legacy tools see fixed codes.
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_INIT_CLR = 2'd1;
    localparam logic [1:0] ST_RUN      = 2'd2;
    localparam logic [1:0] ST_SWAP     = 2'd3;

    // Number of words in one bank for a given address width.
    function automatic int depthOf(input int addrWidth);
        return 1 << addrWidth;
    endfunction

endpackage

// File: rtl/pq_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// pq_buffer_ctrl
// Sequencer for the two-bank ping-pong buffer. The producer fills the write
// bank through port 2, the consumer drains the read bank through port 1, and
// the banks swap once both sides have signalled end-of-frame. Also performs
// the initial clear sweep, the optional zero-on-read write-back and the
// stall that protects a read from its own pending write-back.
//
// Ports
//   clk, rst_n                        clock, async active-low reset
//   start, abort                      begin clear sweep / return to idle
//   prod_wvalid/waddr/wdata/eof       producer request, prod_wready accept
//   cons_rvalid/raddr/eof             consumer request, cons_rready accept
//   cons_dvalid, cons_rdata           read data, one cycle after the read
//   buf_ctrl, buf_clear               bank select and clear to pq_buffer
//   buf_wr_en1/addr1/din1, buf_rd_en1/addr1   port-1 strobes
//   buf_wr_en2/addr2/din2, buf_rd_en2/addr2   port-2 strobes (read tied 0)
//   buf_dout1                         port-1 read data from pq_buffer
//   busy, swap_pulse, swap_cnt        status
// ---------------------------------------------------------------------------
module pq_buffer_ctrl
    import pq_buffer_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int CLR_ON_READ = 1,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  prod_wvalid,
    input  logic [ADDR_WIDTH-1:0] prod_waddr,
    input  logic [DATA_WIDTH-1:0] prod_wdata,
    input  logic                  prod_eof,
    output logic                  prod_wready,
    input  logic                  cons_rvalid,
    input  logic [ADDR_WIDTH-1:0] cons_raddr,
    input  logic                  cons_eof,
    output logic                  cons_rready,
    output logic                  cons_dvalid,
    output logic [DATA_WIDTH-1:0] cons_rdata,
    output logic                  buf_ctrl,
    output logic                  buf_clear,
    output logic                  buf_wr_en1,
    output logic [ADDR_WIDTH-1:0] buf_wr_addr1,
    output logic [DATA_WIDTH-1:0] buf_din1,
    output logic                  buf_rd_en1,
    output logic [ADDR_WIDTH-1:0] buf_rd_addr1,
    output logic                  buf_wr_en2,
    output logic [ADDR_WIDTH-1:0] buf_wr_addr2,
    output logic [DATA_WIDTH-1:0] buf_din2,
    output logic                  buf_rd_en2,
    output logic [ADDR_WIDTH-1:0] buf_rd_addr2,
    input  logic [DATA_WIDTH-1:0] buf_dout1,
    output logic                  busy,
    output logic                  swap_pulse,
    output logic [CNT_WIDTH-1:0]  swap_cnt
);

    localparam int                  DEPTH     = depthOf(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam bit                  WB_EN     = (CLR_ON_READ != 0);

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_clrAddr;
    logic                  r_pDone;
    logic                  r_cDone;
    logic                  r_wbPend;
    logic [ADDR_WIDTH-1:0] r_wbAddr;
    logic                  r_dValid;
    logic                  r_bufCtrl;
    logic [CNT_WIDTH-1:0]  r_swapCnt;

    logic w_init;
    logic w_run;
    logic w_clrLast;
    logic w_hazard;
    logic w_writeAcc;
    logic w_prodEofAcc;
    logic w_readAcc;
    logic w_consEofAcc;
    logic w_swapGo;
    logic w_wbActive;

    // Handshake decode. A read that would hit the word still waiting for its
    // zero write-back is held off for one cycle so it sees the cleared value.
    assign w_init       = (r_state == ST_INIT_CLR);
    assign w_run        = (r_state == ST_RUN);
    assign w_clrLast    = w_init && (r_clrAddr == LAST_ADDR);
    assign w_hazard     = WB_EN && r_wbPend && cons_rvalid && (cons_raddr == r_wbAddr);
    assign prod_wready  = w_run && !r_pDone;
    assign cons_rready  = w_run && !r_cDone && !w_hazard;
    assign w_writeAcc   = prod_wready && prod_wvalid;
    assign w_prodEofAcc = prod_wready && prod_eof;
    assign w_readAcc    = cons_rready && cons_rvalid;
    assign w_consEofAcc = cons_rready && cons_eof;
    assign w_swapGo     = w_run && r_pDone && r_cDone && !r_wbPend;
    assign w_wbActive   = w_run && r_wbPend;

    // Buffer strobes. Port 1 is shared between the clear sweep, the consumer
    // read and the write-back; idle address/data lines are parked at zero.
    assign buf_clear    = w_init;
    assign buf_wr_en1   = w_init || w_wbActive;
    assign buf_wr_addr1 = w_init ? r_clrAddr : (w_wbActive ? r_wbAddr : '0);
    assign buf_din1     = '0;
    assign buf_rd_en1   = w_readAcc;
    assign buf_rd_addr1 = w_readAcc ? cons_raddr : '0;
    assign buf_wr_en2   = w_writeAcc;
    assign buf_wr_addr2 = w_writeAcc ? prod_waddr : '0;
    assign buf_din2     = w_writeAcc ? prod_wdata : '0;
    assign buf_rd_en2   = 1'b0;
    assign buf_rd_addr2 = '0;

    assign cons_dvalid  = r_dValid;
    assign cons_rdata   = r_dValid ? buf_dout1 : '0;
    assign buf_ctrl     = r_bufCtrl;
    assign busy         = (r_state != ST_IDLE);
    assign swap_pulse   = (r_state == ST_SWAP);
    assign swap_cnt     = r_swapCnt;

    // Main sequencer. The clear sweep walks every address once, then the
    // block alternates between RUN and a single SWAP cycle. Abort wins over
    // everything and drops straight back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_clrAddr <= '0;
        end else if (abort) begin
            r_state   <= ST_IDLE;
            r_clrAddr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state   <= ST_INIT_CLR;
                        r_clrAddr <= '0;
                    end
                end
                ST_INIT_CLR: begin
                    if (w_clrLast) r_state <= ST_RUN;
                    else           r_clrAddr <= r_clrAddr + ADDR_WIDTH'(1);
                end
                ST_RUN: begin
                    if (w_swapGo) r_state <= ST_SWAP;
                end
                ST_SWAP: r_state <= ST_RUN;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // End-of-frame flags. After the sweep the read bank holds nothing, so the
    // consumer side starts out already done and the first swap only waits for
    // the producer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pDone <= 1'b0;
            r_cDone <= 1'b0;
        end else if (abort || w_swapGo) begin
            r_pDone <= 1'b0;
            r_cDone <= 1'b0;
        end else if (w_clrLast) begin
            r_pDone <= 1'b0;
            r_cDone <= 1'b1;
        end else begin
            if (w_prodEofAcc) r_pDone <= 1'b1;
            if (w_consEofAcc) r_cDone <= 1'b1;
        end
    end

    // Read pipeline. Every accepted read produces data the next cycle and,
    // with zero-on-read enabled, a write-back of zero to the same address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dValid <= 1'b0;
            r_wbPend <= 1'b0;
            r_wbAddr <= '0;
        end else if (abort) begin
            r_dValid <= 1'b0;
            r_wbPend <= 1'b0;
        end else begin
            r_dValid <= w_readAcc;
            r_wbPend <= WB_EN && w_readAcc;
            if (w_readAcc) r_wbAddr <= cons_raddr;
        end
    end

    // Bank select and swap counter. Both survive an abort so the parent can
    // still tell which bank was last handed over; a fresh sweep zeroes the
    // count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bufCtrl <= 1'b0;
            r_swapCnt <= '0;
        end else if (!abort) begin
            if (w_clrLast) begin
                r_swapCnt <= '0;
            end else if (w_swapGo) begin
                r_bufCtrl <= !r_bufCtrl;
                r_swapCnt <= r_swapCnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_pq_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pq_buffer_ctrl
// Directed bench for pq_buffer_ctrl with a small two-bank memory standing in
// for pq_buffer. Inputs change 1 ns after the rising edge; outputs are checked
// 2 ns later.
// ---------------------------------------------------------------------------
module tb_pq_buffer_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort;
    logic       prod_wvalid, prod_eof, prod_wready;
    logic [3:0] prod_waddr;
    logic [7:0] prod_wdata;
    logic       cons_rvalid, cons_eof, cons_rready, cons_dvalid;
    logic [3:0] cons_raddr;
    logic [7:0] cons_rdata;
    logic       buf_ctrl, buf_clear;
    logic       buf_wr_en1, buf_rd_en1, buf_wr_en2, buf_rd_en2;
    logic [3:0] buf_wr_addr1, buf_rd_addr1, buf_wr_addr2, buf_rd_addr2;
    logic [7:0] buf_din1, buf_din2, buf_dout1;
    logic       busy, swap_pulse;
    logic [15:0] swap_cnt;

    int errCount   = 0;
    int checkCount = 0;

    logic [7:0] mem [2][16];
    logic [7:0] doutModel;

    always #5 clk = ~clk;

    pq_buffer_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .prod_wvalid(prod_wvalid), .prod_waddr(prod_waddr), .prod_wdata(prod_wdata),
        .prod_eof(prod_eof), .prod_wready(prod_wready),
        .cons_rvalid(cons_rvalid), .cons_raddr(cons_raddr), .cons_eof(cons_eof),
        .cons_rready(cons_rready), .cons_dvalid(cons_dvalid), .cons_rdata(cons_rdata),
        .buf_ctrl(buf_ctrl), .buf_clear(buf_clear),
        .buf_wr_en1(buf_wr_en1), .buf_wr_addr1(buf_wr_addr1), .buf_din1(buf_din1),
        .buf_rd_en1(buf_rd_en1), .buf_rd_addr1(buf_rd_addr1),
        .buf_wr_en2(buf_wr_en2), .buf_wr_addr2(buf_wr_addr2), .buf_din2(buf_din2),
        .buf_rd_en2(buf_rd_en2), .buf_rd_addr2(buf_rd_addr2),
        .buf_dout1(buf_dout1), .busy(busy), .swap_pulse(swap_pulse), .swap_cnt(swap_cnt)
    );

    // Stand-in for pq_buffer: port 2 writes the bank selected by buf_ctrl,
    // port 1 works on the other bank, clear zeroes both banks at that address.
    always @(posedge clk) begin
        if (buf_wr_en2) mem[buf_ctrl][buf_wr_addr2] <= buf_din2;
        if (buf_wr_en1) begin
            if (buf_clear) begin
                mem[0][buf_wr_addr1] <= 8'h00;
                mem[1][buf_wr_addr1] <= 8'h00;
            end else begin
                mem[!buf_ctrl][buf_wr_addr1] <= buf_din1;
            end
        end
        if (buf_rd_en1) doutModel <= mem[!buf_ctrl][buf_rd_addr1];
    end
    assign buf_dout1 = doutModel;

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus();
        start = 0; abort = 0; prod_wvalid = 0; prod_waddr = 0; prod_wdata = 0;
        prod_eof = 0; cons_rvalid = 0; cons_raddr = 0; cons_eof = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        applyStimulus();
        nextCycle(); nextCycle();
        #2;
        checkCount++;
        if ({busy, buf_ctrl, buf_clear, buf_wr_en1, prod_wready, cons_rready, cons_dvalid, swap_pulse} !== 8'h00) begin
            errCount++;
            $display("[TB] FAIL reset_flags: got %b want 00000000",
                     {busy, buf_ctrl, buf_clear, buf_wr_en1, prod_wready, cons_rready, cons_dvalid, swap_pulse});
        end
        checkCount++;
        if (swap_cnt !== 16'd0) begin
            errCount++; $display("[TB] FAIL reset_swap_cnt: got %0d want 0", swap_cnt);
        end
        nextCycle();
        rst_n = 1;
    endtask

    task automatic test_init_clear();
        start = 1;
        #2;
        checkCount++;
        if (busy !== 1'b0) begin errCount++; $display("[TB] FAIL idle_busy: got %b want 0", busy); end
        nextCycle();
        start = 0;
        for (int i = 0; i < 16; i++) begin
            #2;
            checkCount++;
            if (buf_clear !== 1'b1 || buf_wr_en1 !== 1'b1 || buf_wr_addr1 !== 4'(i) || buf_din1 !== 8'h00
                || prod_wready !== 1'b0) begin
                errCount++;
                $display("[TB] FAIL sweep_%0d: clr=%b we1=%b a1=%0d d1=%h wr=%b want 1 1 %0d 00 0",
                         i, buf_clear, buf_wr_en1, buf_wr_addr1, buf_din1, prod_wready, i);
            end
            nextCycle();
        end
        #2;
        checkCount++;
        if (buf_clear !== 1'b0 || prod_wready !== 1'b1 || cons_rready !== 1'b0 || busy !== 1'b1 || swap_cnt !== 16'd0) begin
            errCount++;
            $display("[TB] FAIL sweep_exit: clr=%b wr=%b rr=%b busy=%b cnt=%0d want 0 1 0 1 0",
                     buf_clear, prod_wready, cons_rready, busy, swap_cnt);
        end
    endtask

    task automatic test_first_swap();
        prod_wvalid = 1; prod_waddr = 4'd3; prod_wdata = 8'h5A; prod_eof = 1;
        #2;
        checkCount++;
        if (buf_wr_en2 !== 1'b1 || buf_wr_addr2 !== 4'd3 || buf_din2 !== 8'h5A) begin
            errCount++;
            $display("[TB] FAIL port2_write: en=%b a=%0d d=%h want 1 3 5a", buf_wr_en2, buf_wr_addr2, buf_din2);
        end
        nextCycle();
        applyStimulus();
        #2;
        checkCount++;
        if (prod_wready !== 1'b0 || swap_pulse !== 1'b0) begin
            errCount++; $display("[TB] FAIL pre_swap: wr=%b sp=%b want 0 0", prod_wready, swap_pulse);
        end
        nextCycle();
        #2;
        checkCount++;
        if (swap_pulse !== 1'b1 || prod_wready !== 1'b0 || cons_rready !== 1'b0) begin
            errCount++;
            $display("[TB] FAIL swap1: sp=%b wr=%b rr=%b want 1 0 0", swap_pulse, prod_wready, cons_rready);
        end
        nextCycle();
        #2;
        checkCount++;
        if (swap_pulse !== 1'b0 || buf_ctrl !== 1'b1 || swap_cnt !== 16'd1 || cons_rready !== 1'b1 || prod_wready !== 1'b1) begin
            errCount++;
            $display("[TB] FAIL post_swap1: sp=%b ctrl=%b cnt=%0d rr=%b wr=%b want 0 1 1 1 1",
                     swap_pulse, buf_ctrl, swap_cnt, cons_rready, prod_wready);
        end
    endtask

    task automatic test_back_to_back();
        cons_rvalid = 1; cons_raddr = 4'd3;
        #2;
        checkCount++;
        if (cons_rready !== 1'b1 || buf_rd_en1 !== 1'b1 || buf_rd_addr1 !== 4'd3) begin
            errCount++;
            $display("[TB] FAIL read1: rr=%b en=%b a=%0d want 1 1 3", cons_rready, buf_rd_en1, buf_rd_addr1);
        end
        nextCycle();
        #2;
        checkCount++;
        if (cons_dvalid !== 1'b1 || cons_rdata !== 8'h5A) begin
            errCount++; $display("[TB] FAIL read1_data: dv=%b d=%h want 1 5a", cons_dvalid, cons_rdata);
        end
        checkCount++;
        if (buf_wr_en1 !== 1'b1 || buf_wr_addr1 !== 4'd3 || buf_din1 !== 8'h00) begin
            errCount++;
            $display("[TB] FAIL writeback1: en=%b a=%0d d=%h want 1 3 00", buf_wr_en1, buf_wr_addr1, buf_din1);
        end
        checkCount++;
        if (cons_rready !== 1'b0 || buf_rd_en1 !== 1'b0) begin
            errCount++; $display("[TB] FAIL hazard_stall: rr=%b en=%b want 0 0", cons_rready, buf_rd_en1);
        end
        nextCycle();
        #2;
        checkCount++;
        if (cons_rready !== 1'b1 || buf_wr_en1 !== 1'b0 || cons_dvalid !== 1'b0 || buf_rd_en1 !== 1'b1) begin
            errCount++;
            $display("[TB] FAIL read2: rr=%b we1=%b dv=%b re1=%b want 1 0 0 1",
                     cons_rready, buf_wr_en1, cons_dvalid, buf_rd_en1);
        end
        nextCycle();
        cons_raddr = 4'd5;
        #2;
        checkCount++;
        if (cons_dvalid !== 1'b1 || cons_rdata !== 8'h00) begin
            errCount++; $display("[TB] FAIL read2_data: dv=%b d=%h want 1 00", cons_dvalid, cons_rdata);
        end
        checkCount++;
        if (cons_rready !== 1'b1 || buf_wr_en1 !== 1'b1 || buf_wr_addr1 !== 4'd3) begin
            errCount++;
            $display("[TB] FAIL no_stall_other: rr=%b we1=%b a1=%0d want 1 1 3", cons_rready, buf_wr_en1, buf_wr_addr1);
        end
        nextCycle();
        applyStimulus();
        #2;
        checkCount++;
        if (buf_wr_en1 !== 1'b1 || buf_wr_addr1 !== 4'd5) begin
            errCount++; $display("[TB] FAIL writeback3: en=%b a=%0d want 1 5", buf_wr_en1, buf_wr_addr1);
        end
        nextCycle();
    endtask

    task automatic test_eof_order();
        prod_eof = 1;
        #2;
        checkCount++;
        if (prod_wready !== 1'b1) begin errCount++; $display("[TB] FAIL peof_accept: got %b want 1", prod_wready); end
        nextCycle();
        prod_eof = 0;
        for (int i = 0; i < 3; i++) begin
            #2;
            checkCount++;
            if (prod_wready !== 1'b0 || cons_rready !== 1'b1 || swap_pulse !== 1'b0) begin
                errCount++;
                $display("[TB] FAIL prod_wait_%0d: wr=%b rr=%b sp=%b want 0 1 0", i, prod_wready, cons_rready, swap_pulse);
            end
            nextCycle();
        end
        cons_eof = 1;
        nextCycle();
        cons_eof = 0;
        #2;
        checkCount++;
        if (swap_pulse !== 1'b0 || cons_rready !== 1'b0 || prod_wready !== 1'b0) begin
            errCount++;
            $display("[TB] FAIL after_ceof: sp=%b rr=%b wr=%b want 0 0 0", swap_pulse, cons_rready, prod_wready);
        end
        nextCycle();
        #2;
        checkCount++;
        if (swap_pulse !== 1'b1) begin errCount++; $display("[TB] FAIL swap2: got %b want 1", swap_pulse); end
        nextCycle();
        #2;
        checkCount++;
        if (swap_pulse !== 1'b0 || swap_cnt !== 16'd2 || buf_ctrl !== 1'b0 || prod_wready !== 1'b1) begin
            errCount++;
            $display("[TB] FAIL post_swap2: sp=%b cnt=%0d ctrl=%b wr=%b want 0 2 0 1",
                     swap_pulse, swap_cnt, buf_ctrl, prod_wready);
        end
    endtask

    task automatic test_abort();
        abort = 1;
        nextCycle();
        abort = 0;
        #2;
        checkCount++;
        if (busy !== 1'b0 || prod_wready !== 1'b0 || buf_ctrl !== 1'b0 || swap_cnt !== 16'd2) begin
            errCount++;
            $display("[TB] FAIL abort_run: busy=%b wr=%b ctrl=%b cnt=%0d want 0 0 0 2", busy, prod_wready, buf_ctrl, swap_cnt);
        end
        start = 1;
        nextCycle();
        start = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 1) start = 1;
            if (i == 2) start = 0;
            if (i == 7) abort = 1;
            #2;
            checkCount++;
            if (buf_clear !== 1'b1 || buf_wr_addr1 !== 4'(i)) begin
                errCount++;
                $display("[TB] FAIL sweep2_%0d: clr=%b a1=%0d want 1 %0d", i, buf_clear, buf_wr_addr1, i);
            end
            nextCycle();
        end
        abort = 0;
        start = 1;
        #2;
        checkCount++;
        if (buf_clear !== 1'b0 || busy !== 1'b0 || buf_wr_en1 !== 1'b0) begin
            errCount++;
            $display("[TB] FAIL abort_clr: clr=%b busy=%b we1=%b want 0 0 0", buf_clear, busy, buf_wr_en1);
        end
        nextCycle();
        start = 0;
        #2;
        checkCount++;
        if (buf_clear !== 1'b1 || buf_wr_addr1 !== 4'd0) begin
            errCount++; $display("[TB] FAIL restart: clr=%b a1=%0d want 1 0", buf_clear, buf_wr_addr1);
        end
    endtask

    task automatic test_reset_midop();
        nextCycle();
        #2;
        rst_n = 0;
        #1;
        checkCount++;
        if (buf_clear !== 1'b0 || busy !== 1'b0 || swap_cnt !== 16'd0 || buf_wr_en1 !== 1'b0) begin
            errCount++;
            $display("[TB] FAIL reset_midop: clr=%b busy=%b cnt=%0d we1=%b want 0 0 0 0",
                     buf_clear, busy, swap_cnt, buf_wr_en1);
        end
        nextCycle();
        rst_n = 1;
    endtask

    initial begin
        test_reset();
        test_init_clear();
        test_first_swap();
        nextCycle();
        test_back_to_back();
        test_eof_order();
        test_abort();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
